hazard_scoreboard: RTL and testbench

- Parametrised successor to the combinational load-use stall unit for the 5-stage core.
- Tracks destination registers with outstanding writes from multi-cycle loads (configurable latency) and from the iterative mult/div unit.
- Stalls the F/D stage on RAW, WAW-on-multdiv and multdiv structural hazards, and reports the stall cause.
- Sits between the D/X pipeline register and the F/D latch enable; drives F/D hold and D/X nop-insert.

---
 rtl/hazard_scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Register scoreboard for the 5-stage core. Tracks pending writes
//            from multi-cycle loads and from the iterative mult/div unit,
//            stalls F/D on RAW, WAW-on-multdiv and multdiv structural hazards,
//            and reports the stall cause.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int LOAD_LAT  = 1,
  parameter int MD_ENABLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ir_fd,
  input  logic [1:0]       fd_type,
  input  logic [31:0]      ir_dx,
  input  logic             dx_valid,
  input  logic             multdiv_ready,
  output logic             stall,
  output logic [1:0]       stall_cause,
  output logic             md_pending,
  output logic [NREGS-1:0] busy_mask
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [4:0] c_OP_RTYPE = 5'b00000;
  localparam logic [4:0] c_OP_LW    = 5'b01000;
  localparam logic [4:0] c_OP_SW    = 5'b00111;
  localparam logic [4:0] c_OP_BNE   = 5'b00010;
  localparam logic [4:0] c_OP_BLT   = 5'b00110;
  localparam logic [4:0] c_ALU_MUL  = 5'b00110;
  localparam logic [4:0] c_ALU_DIV  = 5'b00111;

  localparam logic [1:0] c_T_R   = 2'b00;
  localparam logic [1:0] c_T_I   = 2'b01;
  localparam logic [1:0] c_T_JII = 2'b11;

  localparam logic [1:0] c_CAUSE_NONE = 2'b00;
  localparam logic [1:0] c_CAUSE_LOAD = 2'b01;
  localparam logic [1:0] c_CAUSE_MDRW = 2'b10;
  localparam logic [1:0] c_CAUSE_MDST = 2'b11;

  localparam logic [2:0] c_LOAD_INIT = 3'(LOAD_LAT - 1);

  // One-hot of a register index; register 0 and out-of-range indices map to
  // nothing, so callers never need to filter out $0 themselves.
  function automatic logic [NREGS-1:0] f_onehot(input logic [RW-1:0] idx,
                                                input logic en);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (en && (idx == RW'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Instruction fields
  logic [4:0]    w_fd_op, w_fd_alu, w_dx_op, w_dx_alu;
  logic [RW-1:0] w_fd_rd, w_fd_rs, w_fd_rt, w_dx_rd;

  assign w_fd_op  = ir_fd[31:27];
  assign w_fd_alu = ir_fd[6:2];
  assign w_fd_rd  = ir_fd[22 +: RW];
  assign w_fd_rs  = ir_fd[17 +: RW];
  assign w_fd_rt  = ir_fd[12 +: RW];
  assign w_dx_op  = ir_dx[31:27];
  assign w_dx_alu = ir_dx[6:2];
  assign w_dx_rd  = ir_dx[22 +: RW];

  // Not every instruction bit is decoded here; fold them into one sink.
  logic w_unused;
  assign w_unused = ^{ir_fd, ir_dx, multdiv_ready};

  logic             w_fd_is_md;
  logic             w_use_rs, w_use_rt, w_use_rd;
  logic [NREGS-1:0] w_src_mask;
  logic [NREGS-1:0] w_tgt_mask;
  logic             w_ld_issue;
  logic [NREGS-1:0] w_ld_onehot;

  // Decode which F/D fields are read as sources and whether F/D is a mult/div.
  always_comb begin
    w_fd_is_md = (fd_type == c_T_R) && (w_fd_op == c_OP_RTYPE) &&
                 ((w_fd_alu == c_ALU_MUL) || (w_fd_alu == c_ALU_DIV));
    w_use_rs   = (fd_type == c_T_R) || (fd_type == c_T_I);
    w_use_rt   = (fd_type == c_T_R);
    w_use_rd   = (fd_type == c_T_JII) ||
                 ((fd_type == c_T_I) &&
                  ((w_fd_op == c_OP_SW) || (w_fd_op == c_OP_BNE) ||
                   (w_fd_op == c_OP_BLT)));
    w_src_mask = f_onehot(w_fd_rs, w_use_rs) |
                 f_onehot(w_fd_rt, w_use_rt) |
                 f_onehot(w_fd_rd, w_use_rd);
    w_tgt_mask = f_onehot(w_fd_rd, w_fd_is_md);
    w_ld_issue = dx_valid && (w_dx_op == c_OP_LW) && (w_dx_rd != '0);
    w_ld_onehot = f_onehot(w_dx_rd, w_ld_issue);
  end

  // Per-register load down-counters; busy while nonzero.
  logic [NREGS-1:0] w_cnt_nz;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    if (gi == 0) begin : g_zero
      assign w_cnt_nz[gi] = 1'b0;
    end else begin : g_reg
      logic [2:0] r_cnt;
      // Reload on a new load to this register, otherwise count down to zero.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_cnt <= 3'd0;
        end else if (w_ld_onehot[gi]) begin
          r_cnt <= c_LOAD_INIT;
        end else if (r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
      assign w_cnt_nz[gi] = (r_cnt != 3'd0);
    end
  end

  // Mult/div tracking
  logic          r_md_busy;
  logic [RW-1:0] r_md_rd;
  logic          w_md_issue;

  if (MD_ENABLE != 0) begin : g_md
    assign w_md_issue = dx_valid && (w_dx_op == c_OP_RTYPE) &&
                        ((w_dx_alu == c_ALU_MUL) || (w_dx_alu == c_ALU_DIV)) &&
                        (w_dx_rd != '0);
    // A new issue takes precedence over a completion in the same cycle.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_md_busy <= 1'b0;
        r_md_rd   <= '0;
      end else if (w_md_issue) begin
        r_md_busy <= 1'b1;
        r_md_rd   <= w_dx_rd;
      end else if (multdiv_ready) begin
        r_md_busy <= 1'b0;
      end
    end
  end else begin : g_no_md
    assign w_md_issue = 1'b0;
    assign r_md_busy  = 1'b0;
    assign r_md_rd    = '0;
  end

  logic             w_md_live;
  logic             w_md_pend_now;
  logic [NREGS-1:0] w_md_mask;
  logic [NREGS-1:0] w_ld_busy;

  // Hazard evaluation and cause priority; a completing mult/div is free now.
  always_comb begin
    w_md_live     = r_md_busy && !multdiv_ready;
    w_md_pend_now = w_md_live || w_md_issue;
    w_md_mask     = f_onehot(w_dx_rd, w_md_issue) | f_onehot(r_md_rd, w_md_live);
    w_ld_busy     = w_cnt_nz | w_ld_onehot;
    stall_cause   = c_CAUSE_NONE;
    if (reset) begin
      stall_cause = c_CAUSE_NONE;
    end else if (w_fd_is_md && w_md_pend_now) begin
      stall_cause = c_CAUSE_MDST;
    end else if (|((w_src_mask | w_tgt_mask) & w_md_mask)) begin
      stall_cause = c_CAUSE_MDRW;
    end else if (|(w_src_mask & w_ld_busy)) begin
      stall_cause = c_CAUSE_LOAD;
    end
    stall = (stall_cause != c_CAUSE_NONE);
  end

  // Visible state: registered busy bits only, forced clear while in reset.
  always_comb begin
    busy_mask  = '0;
    md_pending = 1'b0;
    if (!reset) begin
      busy_mask  = w_cnt_nz | f_onehot(r_md_rd, r_md_busy);
      md_pending = r_md_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard; two instances
//            (LOAD_LAT 1 and 3) share stimulus and are compared against a
//            cycle-timestamp reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset;
  logic [31:0] ir_fd;
  logic [1:0]  fd_type;
  logic [31:0] ir_dx;
  logic        dx_valid;
  logic        multdiv_ready;

  logic        stall1, stall3;
  logic [1:0]  cause1, cause3;
  logic        mdp1, mdp3;
  logic [31:0] mask1, mask3;

  hazard_scoreboard #(.NREGS(32), .LOAD_LAT(1), .MD_ENABLE(1)) u_dut1 (
    .clock(clock), .reset(reset), .ir_fd(ir_fd), .fd_type(fd_type),
    .ir_dx(ir_dx), .dx_valid(dx_valid), .multdiv_ready(multdiv_ready),
    .stall(stall1), .stall_cause(cause1), .md_pending(mdp1), .busy_mask(mask1)
  );

  hazard_scoreboard #(.NREGS(32), .LOAD_LAT(3), .MD_ENABLE(1)) u_dut3 (
    .clock(clock), .reset(reset), .ir_fd(ir_fd), .fd_type(fd_type),
    .ir_dx(ir_dx), .dx_valid(dx_valid), .multdiv_ready(multdiv_ready),
    .stall(stall3), .stall_cause(cause3), .md_pending(mdp3), .busy_mask(mask3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state: cycle at which each register's load result is free,
  // and the outstanding mult/div destination.
  int ld_free [2][32];
  bit md_b;
  int md_r;
  int lat_of [2] = '{1, 3};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int alu);
    logic [31:0] v;
    v        = $urandom;
    v[31:27] = op[4:0];
    v[26:22] = rd[4:0];
    v[21:17] = rs[4:0];
    v[16:12] = rt[4:0];
    v[6:2]   = alu[4:0];
    return v;
  endfunction

  // Apply one cycle of inputs, check both DUTs mid-cycle, advance the model.
  task automatic step(input logic rst, input logic [31:0] fd,
                      input logic [1:0] ft, input logic [31:0] dx,
                      input logic dv, input logic rdy);
    int fop, falu, frd, frs, frt, dop, dalu, drd;
    bit [31:0] srcm;
    bit fd_md, ld_iss, md_iss, md_live, pend, md_hit, ld_hit;
    logic [1:0] ecause;
    logic [31:0] emask;
    reset = rst; ir_fd = fd; fd_type = ft; ir_dx = dx;
    dx_valid = dv; multdiv_ready = rdy;
    @(negedge clock);
    fop = int'(fd[31:27]); frd = int'(fd[26:22]); frs = int'(fd[21:17]);
    frt = int'(fd[16:12]); falu = int'(fd[6:2]);
    dop = int'(dx[31:27]); drd = int'(dx[26:22]); dalu = int'(dx[6:2]);
    srcm = '0;
    if ((ft == 2'd0 || ft == 2'd1) && frs != 0) srcm[frs] = 1'b1;
    if (ft == 2'd0 && frt != 0) srcm[frt] = 1'b1;
    if (((ft == 2'd1 && (fop == 7 || fop == 2 || fop == 6)) || ft == 2'd3) && frd != 0)
      srcm[frd] = 1'b1;
    fd_md   = (ft == 2'd0) && (fop == 0) && (falu == 6 || falu == 7);
    ld_iss  = dv && (dop == 8) && (drd != 0);
    md_iss  = dv && (dop == 0) && (dalu == 6 || dalu == 7) && (drd != 0);
    md_live = md_b && !rdy;
    pend    = md_live || md_iss;
    md_hit  = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (((md_iss && drd == r) || (md_live && md_r == r)) &&
          (srcm[r] || (fd_md && frd == r)))
        md_hit = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      ld_hit = 1'b0;
      emask  = '0;
      for (int r = 1; r < 32; r++) begin
        if (srcm[r] && ((cyc < ld_free[k][r]) || (ld_iss && drd == r))) ld_hit = 1'b1;
        emask[r] = (cyc < ld_free[k][r]) || (md_b && md_r == r);
      end
      if (rst)               ecause = 2'b00;
      else if (fd_md && pend) ecause = 2'b11;
      else if (md_hit)        ecause = 2'b10;
      else if (ld_hit)        ecause = 2'b01;
      else                    ecause = 2'b00;
      if (rst) emask = '0;
      if (k == 0) begin
        check("L1 stall", 64'(stall1), 64'(ecause != 2'b00));
        check("L1 cause", 64'(cause1), 64'(ecause));
        check("L1 busy_mask", 64'(mask1), 64'(emask));
        check("L1 md_pending", 64'(mdp1), 64'(md_b && !rst));
      end else begin
        check("L3 stall", 64'(stall3), 64'(ecause != 2'b00));
        check("L3 cause", 64'(cause3), 64'(ecause));
        check("L3 busy_mask", 64'(mask3), 64'(emask));
        check("L3 md_pending", 64'(mdp3), 64'(md_b && !rst));
      end
    end
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 32; r++) ld_free[k][r] = 0;
      md_b = 1'b0;
      md_r = 0;
    end else begin
      if (ld_iss)
        for (int k = 0; k < 2; k++) ld_free[k][drd] = cyc + lat_of[k];
      if (md_iss) begin
        md_b = 1'b1;
        md_r = drd;
      end else if (rdy) begin
        md_b = 1'b0;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] nop_i;
  int ops_i [5] = '{8, 7, 2, 6, 5};

  initial begin
    int ft, fop, falu, kind, dop, dalu;
    logic [31:0] fd, dx;
    bit rdy;
    md_b = 1'b0; md_r = 0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) ld_free[k][r] = 0;
    reset = 1'b1; ir_fd = '0; fd_type = '0; ir_dx = '0;
    dx_valid = 1'b0; multdiv_ready = 1'b0;
    nop_i = mk(0, 0, 0, 0, 0);
    @(posedge clock); #1;
    step(1, nop_i, 0, nop_i, 0, 0);
    step(1, nop_i, 0, nop_i, 0, 0);
    // Load-use: lw $5 then add $6,$5,$2 with bubbles behind
    step(0, mk(0, 6, 5, 2, 0), 0, mk(8, 5, 1, 0, 0), 1, 0);
    for (int i = 0; i < 4; i++) step(0, mk(0, 6, 5, 2, 0), 0, nop_i, 0, 0);
    // mul $7 pending: RAW, WAW, structural, then ready + new div issue
    step(0, mk(0, 1, 7, 0, 0), 0, mk(0, 7, 1, 2, 6), 1, 0);
    step(0, mk(0, 1, 7, 0, 0), 0, nop_i, 0, 0);
    step(0, mk(0, 7, 1, 1, 0), 0, nop_i, 0, 0);
    step(0, mk(0, 9, 1, 2, 7), 0, nop_i, 0, 0);
    step(0, mk(0, 1, 7, 0, 0), 0, mk(0, 9, 1, 2, 7), 1, 1);
    step(0, mk(0, 1, 9, 0, 0), 0, nop_i, 0, 0);
    step(0, mk(0, 1, 9, 0, 0), 0, nop_i, 0, 1);
    step(0, mk(0, 1, 9, 0, 0), 0, nop_i, 0, 0);
    // $0 destinations, sw source on rd, JI never stalls
    step(0, mk(0, 1, 0, 0, 0), 0, mk(8, 0, 1, 0, 0), 1, 0);
    step(0, mk(0, 9, 0, 0, 6), 0, mk(0, 0, 1, 2, 6), 1, 0);
    step(0, mk(7, 5, 3, 0, 0), 1, mk(8, 5, 1, 0, 0), 1, 0);
    step(0, mk(7, 5, 3, 0, 0), 1, nop_i, 0, 0);
    step(0, mk(1, 5, 5, 5, 0), 2, mk(8, 5, 1, 0, 0), 1, 0);
    // Reset mid-operation
    step(0, nop_i, 0, mk(8, 4, 1, 0, 0), 1, 0);
    step(0, nop_i, 0, mk(0, 8, 1, 2, 6), 1, 0);
    step(1, mk(0, 1, 4, 8, 0), 0, nop_i, 0, 0);
    step(0, mk(0, 1, 4, 8, 0), 0, nop_i, 0, 0);
    step(0, mk(0, 1, 4, 8, 0), 0, nop_i, 0, 0);
    // Randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 4000; n++) begin
      ft = $urandom_range(0, 3);
      case (ft)
        0: begin
          fop = 0;
          case ($urandom_range(0, 3))
            0:       falu = 6;
            1:       falu = 7;
            default: falu = $urandom_range(0, 31);
          endcase
        end
        1:       begin fop = ops_i[$urandom_range(0, 4)]; falu = $urandom_range(0, 31); end
        2:       begin fop = ($urandom_range(0, 1) == 0) ? 1 : 3; falu = 0; end
        default: begin fop = 4; falu = 0; end
      endcase
      fd = mk(fop, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), falu);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       begin dop = 8; dalu = $urandom_range(0, 31); end
        1:       begin dop = 0; dalu = 6 + $urandom_range(0, 1); end
        2:       begin dop = 0; dalu = 0; end
        default: begin dop = $urandom_range(0, 31); dalu = $urandom_range(0, 31); end
      endcase
      dx = mk(dop, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), dalu);
      rdy = md_b ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 59) == 0, fd, 2'(ft), dx, $urandom_range(0, 4) != 0, rdy);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
